// File: rtl/decode_queue.sv
// Decode buffer between Fetch and Issue: a DEPTH-entry instruction FIFO with
// valid/ready handshakes on both sides and field extraction from the head entry.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_id_valid,
  input  logic [31:0]      if_id_instruc,
  input  logic [31:0]      if_id_nextpc,
  output logic             id_if_ready,
  input  logic             flush,
  output logic             id_iss_valid,
  input  logic             iss_id_ready,
  output logic [5:0]       id_iss_op,
  output logic [5:0]       id_iss_funct,
  output logic [4:0]       id_iss_addra,
  output logic [4:0]       id_iss_addrb,
  output logic [4:0]       id_iss_shamt,
  output logic [4:0]       id_iss_regdest,
  output logic [31:0]      id_iss_imedext,
  output logic [31:0]      id_iss_nextpc,
  output logic [CNT_W-1:0] id_iss_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] nextpc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  entry_t           head;

  assign id_if_ready  = (count != FULL);
  assign id_iss_valid = (count != '0);
  assign id_iss_count = count;

  // Flush outranks both handshakes, so neither side may move during it.
  assign push = if_id_valid && id_if_ready && !flush;
  assign pop  = id_iss_valid && iss_id_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry array is deliberately not reset; stale contents are never
  // visible because every head output is masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= '{instr: if_id_instruc, nextpc: if_id_nextpc};
  end

  assign head = mem[rptr];

  // NOTE: every output gets a default before the conditional assignments so
  // no path leaves a value held, which would infer a latch.
  always_comb begin
    id_iss_op      = '0;
    id_iss_funct   = '0;
    id_iss_addra   = '0;
    id_iss_addrb   = '0;
    id_iss_shamt   = '0;
    id_iss_regdest = '0;
    id_iss_imedext = '0;
    id_iss_nextpc  = '0;
    if (id_iss_valid) begin
      id_iss_op     = head.instr[31:26];
      id_iss_funct  = head.instr[5:0];
      id_iss_addra  = head.instr[25:21];
      id_iss_addrb  = head.instr[20:16];
      id_iss_shamt  = head.instr[10:6];
      id_iss_nextpc = head.nextpc;
      // R-type writes rd; everything else writes rt.
      id_iss_regdest = (head.instr[31:26] == 6'h00) ? head.instr[15:11]
                                                    : head.instr[20:16];
      // Logical immediates (ANDI/ORI/XORI) zero-extend; all others sign-extend.
      unique case (head.instr[31:26])
        6'h0C, 6'h0D, 6'h0E: id_iss_imedext = {16'h0000, head.instr[15:0]};
        default:             id_iss_imedext = {{16{head.instr[15]}}, head.instr[15:0]};
      endcase
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, fill/drain, wrap, extension, flush
// and asynchronous reset, with hand-computed expected values.
module tb_decode_queue;

  logic        clock;
  logic        reset;
  logic        if_id_valid;
  logic [31:0] if_id_instruc;
  logic [31:0] if_id_nextpc;
  logic        id_if_ready;
  logic        flush;
  logic        id_iss_valid;
  logic        iss_id_ready;
  logic [5:0]  id_iss_op;
  logic [5:0]  id_iss_funct;
  logic [4:0]  id_iss_addra;
  logic [4:0]  id_iss_addrb;
  logic [4:0]  id_iss_shamt;
  logic [4:0]  id_iss_regdest;
  logic [31:0] id_iss_imedext;
  logic [31:0] id_iss_nextpc;
  logic [2:0]  id_iss_count;

  int total = 0;
  int bad   = 0;

  decode_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_id_valid    (if_id_valid),
    .if_id_instruc  (if_id_instruc),
    .if_id_nextpc   (if_id_nextpc),
    .id_if_ready    (id_if_ready),
    .flush          (flush),
    .id_iss_valid   (id_iss_valid),
    .iss_id_ready   (iss_id_ready),
    .id_iss_op      (id_iss_op),
    .id_iss_funct   (id_iss_funct),
    .id_iss_addra   (id_iss_addra),
    .id_iss_addrb   (id_iss_addrb),
    .id_iss_shamt   (id_iss_shamt),
    .id_iss_regdest (id_iss_regdest),
    .id_iss_imedext (id_iss_imedext),
    .id_iss_nextpc  (id_iss_nextpc),
    .id_iss_count   (id_iss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++; if (id_if_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", id_if_ready); end
    total++; if (id_iss_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_iss_valid); end
    total++; if (id_iss_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", id_iss_count); end
    total++; if (id_iss_imedext !== 32'h0) begin bad++; $display("FAIL reset_imedext got=%h exp=0", id_iss_imedext); end
    total++; if (id_iss_regdest !== 5'd0) begin bad++; $display("FAIL reset_regdest got=%0d exp=0", id_iss_regdest); end
    total++; if (id_iss_nextpc !== 32'h0) begin bad++; $display("FAIL reset_nextpc got=%h exp=0", id_iss_nextpc); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] prog [4];
    prog[0] = 32'h20080005;
    prog[1] = 32'h2009FFFF;
    prog[2] = 32'h01095020;
    prog[3] = 32'h3C0B1234;
    iss_id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_id_valid   = 1'b1;
      if_id_instruc = prog[i];
      if_id_nextpc  = 32'h100 + 32'(4 * i);
      tick();
    end
    total++; if (id_iss_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", id_iss_count); end
    total++; if (id_if_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", id_if_ready); end
    // Fifth instruction held on the input while full.
    if_id_instruc = 32'h11111111;
    if_id_nextpc  = 32'h999;
    tick();
    total++; if (id_iss_count !== 3'd4) begin bad++; $display("FAIL full_hold_count got=%0d exp=4", id_iss_count); end
    total++; if (id_iss_nextpc !== 32'h100) begin bad++; $display("FAIL full_hold_head got=%h exp=100", id_iss_nextpc); end
    if_id_valid  = 1'b0;
    iss_id_ready = 1'b1;
    total++; if (id_iss_regdest !== 5'd8) begin bad++; $display("FAIL drain0_regdest got=%0d exp=8", id_iss_regdest); end
    total++; if (id_iss_imedext !== 32'h00000005) begin bad++; $display("FAIL drain0_imedext got=%h exp=00000005", id_iss_imedext); end
    tick();
    total++; if (id_if_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", id_if_ready); end
    total++; if (id_iss_regdest !== 5'd9) begin bad++; $display("FAIL drain1_regdest got=%0d exp=9", id_iss_regdest); end
    total++; if (id_iss_imedext !== 32'hFFFFFFFF) begin bad++; $display("FAIL drain1_imedext got=%h exp=ffffffff", id_iss_imedext); end
    tick();
    total++; if (id_iss_regdest !== 5'd10) begin bad++; $display("FAIL drain2_regdest got=%0d exp=10", id_iss_regdest); end
    total++; if (id_iss_addra !== 5'd8) begin bad++; $display("FAIL drain2_addra got=%0d exp=8", id_iss_addra); end
    total++; if (id_iss_addrb !== 5'd9) begin bad++; $display("FAIL drain2_addrb got=%0d exp=9", id_iss_addrb); end
    total++; if (id_iss_funct !== 6'h20) begin bad++; $display("FAIL drain2_funct got=%h exp=20", id_iss_funct); end
    tick();
    total++; if (id_iss_op !== 6'h0F) begin bad++; $display("FAIL drain3_op got=%h exp=0f", id_iss_op); end
    total++; if (id_iss_nextpc !== 32'h10C) begin bad++; $display("FAIL drain3_nextpc got=%h exp=10c", id_iss_nextpc); end
    tick();
    total++; if (id_iss_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got=%b exp=0", id_iss_valid); end
    total++; if (id_iss_nextpc !== 32'h0) begin bad++; $display("FAIL drain_empty_nextpc got=%h exp=0", id_iss_nextpc); end
    iss_id_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    iss_id_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_id_valid   = 1'b1;
      if_id_instruc = 32'h20000000 | 32'(k);
      if_id_nextpc  = 32'h1000 + 32'(k);
      tick();
    end
    iss_id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if_id_instruc = 32'h20000000 | 32'(i + 2);
      if_id_nextpc  = 32'h1000 + 32'(i + 2);
      total++; if (id_iss_nextpc !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL wrap_head[%0d] got=%h exp=%h", i, id_iss_nextpc, 32'h1000 + 32'(i)); end
      tick();
      total++; if (id_iss_count !== 3'd2) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, id_iss_count); end
    end
    if_id_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      total++; if (id_iss_nextpc !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", i, id_iss_nextpc, 32'h1000 + 32'(i)); end
      tick();
    end
    total++; if (id_iss_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", id_iss_valid); end
    iss_id_ready = 1'b0;
  endtask

  task automatic test_extension();
    iss_id_ready  = 1'b0;
    if_id_valid   = 1'b1;
    if_id_instruc = 32'h3508FFFF;
    if_id_nextpc  = 32'h2000;
    tick();
    total++; if (id_iss_imedext !== 32'h0000FFFF) begin bad++; $display("FAIL ori_imedext got=%h exp=0000ffff", id_iss_imedext); end
    total++; if (id_iss_regdest !== 5'd8) begin bad++; $display("FAIL ori_regdest got=%0d exp=8", id_iss_regdest); end
    // Pop ORI while pushing ADDI.
    iss_id_ready  = 1'b1;
    if_id_instruc = 32'h2108FFFF;
    if_id_nextpc  = 32'h2004;
    tick();
    if_id_valid = 1'b0;
    total++; if (id_iss_imedext !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imedext got=%h exp=ffffffff", id_iss_imedext); end
    total++; if (id_iss_nextpc !== 32'h2004) begin bad++; $display("FAIL addi_nextpc got=%h exp=2004", id_iss_nextpc); end
    tick();
    iss_id_ready = 1'b0;
  endtask

  task automatic test_flush();
    iss_id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_id_valid   = 1'b1;
      if_id_instruc = 32'h20000000 | 32'(k);
      if_id_nextpc  = 32'h3000 + 32'(k);
      tick();
    end
    total++; if (id_iss_count !== 3'd3) begin bad++; $display("FAIL preflush_count got=%0d exp=3", id_iss_count); end
    flush         = 1'b1;
    iss_id_ready  = 1'b1;
    if_id_instruc = 32'h200000AA;
    if_id_nextpc  = 32'h30AA;
    tick();
    flush        = 1'b0;
    iss_id_ready = 1'b0;
    total++; if (id_iss_count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", id_iss_count); end
    total++; if (id_iss_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", id_iss_valid); end
    total++; if (id_if_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", id_if_ready); end
    if_id_instruc = 32'h200000BB;
    if_id_nextpc  = 32'h30BB;
    tick();
    if_id_valid = 1'b0;
    total++; if (id_iss_count !== 3'd1) begin bad++; $display("FAIL postflush_count got=%0d exp=1", id_iss_count); end
    total++; if (id_iss_nextpc !== 32'h30BB) begin bad++; $display("FAIL postflush_head got=%h exp=30bb", id_iss_nextpc); end
    iss_id_ready = 1'b1;
    tick();
    iss_id_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      if_id_valid   = 1'b1;
      if_id_instruc = 32'h20000000 | 32'(k);
      if_id_nextpc  = 32'h4000 + 32'(k);
      tick();
    end
    if_id_valid = 1'b0;
    total++; if (id_iss_count !== 3'd2) begin bad++; $display("FAIL prereset_count got=%0d exp=2", id_iss_count); end
    #2 reset = 1'b1;
    #1;
    total++; if (id_iss_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", id_iss_valid); end
    total++; if (id_iss_count !== 3'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", id_iss_count); end
    total++; if (id_iss_nextpc !== 32'h0) begin bad++; $display("FAIL async_nextpc got=%h exp=0", id_iss_nextpc); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (id_iss_valid !== 1'b0) begin bad++; $display("FAIL postreset_valid got=%b exp=0", id_iss_valid); end
  endtask

  initial begin
    reset         = 1'b1;
    if_id_valid   = 1'b0;
    if_id_instruc = 32'h0;
    if_id_nextpc  = 32'h0;
    flush         = 1'b0;
    iss_id_ready  = 1'b0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_extension();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode buffer between Fetch and Issue. It replaces the single decode pipeline register, and its `iss_stall` freeze, with a DEPTH-entry instruction FIFO that uses valid/ready handshakes on both sides. Per-instruction fields are extracted from the head entry. Fetch can keep running while Issue stalls, and a flush empties the queue in one cycle when a branch or jump redirects the PC.

## Interface

Parameters:
- `DEPTH`, default 4: number of queue entries; a power of two, ≥ 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `if_id_valid`  in  1  Fetch presents an instruction this cycle.
- `if_id_instruc`  in  32  instruction word.
- `if_id_nextpc`  in  32  PC+4 of that instruction.
- `id_if_ready`  out  1  queue can accept an instruction.
- `flush`  in  1  discard all queued instructions and the current push.
- `id_iss_valid`  out  1  head entry is valid.
- `iss_id_ready`  in  1  Issue consumes the head this cycle.
- `id_iss_op`  out  6  head `instr[31:26]`.
- `id_iss_funct`  out  6  head `instr[5:0]`.
- `id_iss_addra`  out  5  head `instr[25:21]`.
- `id_iss_addrb`  out  5  head `instr[20:16]`.
- `id_iss_shamt`  out  5  head `instr[10:6]`.
- `id_iss_regdest`  out  5  destination register (see Operation).
- `id_iss_imedext`  out  32  extended immediate (see Operation).
- `id_iss_nextpc`  out  32  head nextpc.
- `id_iss_count`  out  CNT_W  current occupancy, range 0..DEPTH.

## Operation

- **Storage:** DEPTH entries of {instr[31:0], nextpc[31:0]}, plus a read pointer and a write pointer, each log2(DEPTH) bits, and `count`.
- **Push:** occurs when `if_id_valid && id_if_ready && !flush`. The entry is written at wptr, and wptr advances modulo DEPTH (natural wrap).
- **Pop:** occurs when `id_iss_valid && iss_id_ready && !flush`. rptr advances modulo DEPTH.
- **count update:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop; both pointers still advance.
- **Ready/valid:**
  - `id_if_ready = (count != DEPTH)`. There is no same-cycle pass-through when full, so no combinational path exists from `iss_id_ready` to `id_if_ready`.
  - `id_iss_valid = (count != 0)`.
- **Flush:**
  - Has priority over push and pop.
  - At the next edge: rptr = wptr = 0 and count = 0.
  - Entry contents may be left stale, because outputs are masked when empty.
- **Field extraction:** purely combinational from the entry at rptr.
  - `regdest` = `instr[15:11]` when op == 6'h00 (R-type); otherwise `instr[20:16]`.
  - `imedext` is zero-extended `instr[15:0]` for op 6'h0C (ANDI), 6'h0D (ORI) and 6'h0E (XORI).
  - `imedext` is sign-extended `instr[15:0]` for every other op.
- **Empty masking:** when `count == 0`, every field output (op, funct, addra, addrb, shamt, regdest, imedext, nextpc) is driven to 0.
- **Reset:**
  - Asserting `reset` forces pointers and count to 0 asynchronously.
  - All outputs: `id_if_ready` = 1, `id_iss_valid` = 0, all field outputs = 0, `id_iss_count` = 0.
  - Reset asserted mid-operation discards all entries; a push on a cycle in which reset is asserted is lost.

## Timing

- **Push-to-visible latency:** 1 cycle. An instruction pushed at edge N appears at the head outputs after edge N if the queue was empty.
- **Pop:** the next entry appears immediately after the popping edge.
- **Full:** with DEPTH pushes and no pops, `id_if_ready` falls after the DEPTH-th edge. A pop at edge M raises it after edge M, and a push is accepted on the following cycle.
- **Empty:** `id_iss_valid` falls after the edge that pops the last entry.
- **Flush:** the flush asserted before edge N leaves the queue empty after edge N. `id_if_ready` = 1 and `id_iss_valid` = 0 in cycle N+1, and new pushes are accepted from that cycle.
- **Ordering:** strictly FIFO. Wrap-around is invisible at the outputs.

## Test plan

- **Reset state:** assert reset for 2 cycles, then release. Required: ready = 1, valid = 0, count = 0, and imedext, regdest and nextpc = 0.
- **Fill and drain** (DEPTH = 4, `iss_id_ready` = 0): push instrs 0x20080005, 0x2009FFFF, 0x01095020, 0x3C0B1234.
  - After 4 edges: count = 4 and ready = 0.
  - A 5th instruction held on the input is not accepted.
  - Raise ready and pop in order. Required heads: regdest 8 with imedext 0x00000005; regdest 9 with imedext 0xFFFFFFFF; regdest 10 (R-type) with addra 8 and addrb 9; op 0x0F.
  - Then valid = 0.
- **Wrap with simultaneous push/pop:** keep count at 2 while pushing and popping every cycle for 10 cycles. Required: count stays 2 and the output order matches the input order across pointer wrap.
- **Zero extension:** push ORI 0x3508FFFF. Required: imedext = 0x0000FFFF. Push ADDI 0x2108FFFF. Required: imedext = 0xFFFFFFFF.
- **Flush priority:** with count = 3, assert flush together with `if_id_valid` and `iss_id_ready`. After the edge: count = 0, valid = 0, and the concurrent push is dropped. The next push appears alone at the head.
- **Async reset mid-stream:** with count = 2, assert reset between edges. Required: valid = 0 and count = 0 before the next clock edge.
